bit_pattern_player: RTL and testbench

- Serial bit-stream source: plays back a stored 1-bit pattern on `bitOut` at a programmable prescaled rate.
- Counterpart of the bit sampler/plotter: that block captures a bit stream into block RAM for VGA display; this block drives one.
- Pattern is written through a load port into a 2^ADDR_WIDTH x 1 RAM, then played once or looped.

---
 rtl/bit_pattern_player.sv | 178 +++++++++++++++++
 tb/tb_bit_pattern_player.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_pattern_player.sv
// bit_pattern_player: plays a stored 1-bit pattern serially
// at a programmable prescaled bit rate, once or looped.
module bit_pattern_player #(
  parameter int ADDR_WIDTH     = 14,
  parameter int PRESCALE_WIDTH = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      loadEnable,
  input  logic [ADDR_WIDTH-1:0]     loadAddress,
  input  logic                      loadData,
  input  logic [ADDR_WIDTH-1:0]     length,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      loop,
  input  logic                      start,
  input  logic                      stop,
  output logic                      bitOut,
  output logic                      bitStrobe,
  output logic [ADDR_WIDTH-1:0]     bitIndex,
  output logic                      busy,
  output logic                      done
);

  localparam int Depth = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic                      bit_out_q, bit_out_d;
  logic                      strobe_q, strobe_d;
  logic [ADDR_WIDTH-1:0]     idx_q, idx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]     len_q, len_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic                      loop_q, loop_d;

  logic                      mem [Depth];
  logic                      rd_data_q;
  logic [ADDR_WIDTH-1:0]     rd_addr;

  logic [ADDR_WIDTH-1:0]     zero_next;
  logic [ADDR_WIDTH-1:0]     cur_next;
  logic [ADDR_WIDTH-1:0]     emit_next;

  function automatic logic [ADDR_WIDTH-1:0] wrap_next(
    input logic [ADDR_WIDTH-1:0] i,
    input logic [ADDR_WIDTH-1:0] last
  );
    return (i == last) ? '0 : i + ADDR_WIDTH'(1);
  endfunction

  // Index successors: after the current bit, and after the one being emitted.
  always_comb begin
    zero_next = wrap_next('0, len_q);
    cur_next  = wrap_next(idx_q, len_q);
    emit_next = wrap_next(cur_next, len_q);
  end

  // Pattern RAM: synchronous write, registered read (old data on collision).
  always_ff @(posedge clk) begin
    if (loadEnable) begin
      mem[loadAddress] <= loadData;
    end
    rd_data_q <= mem[rd_addr];
  end

  // Next-state logic; rd_addr always points one bit ahead of the
  // bit that will be on bitOut after this edge, so prescale=0 has no gaps.
  always_comb begin
    state_d   = state_q;
    bit_out_d = bit_out_q;
    strobe_d  = 1'b0;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    len_d     = len_q;
    pre_d     = pre_q;
    loop_d    = loop_q;
    rd_addr   = '0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !stop) begin
          state_d = PRIME;
          busy_d  = 1'b1;
          len_d   = length;
          pre_d   = prescale;
          loop_d  = loop;
        end
      end
      PRIME: begin
        rd_addr = zero_next;
        if (stop) begin
          state_d   = IDLE;
          bit_out_d = 1'b0;
          busy_d    = 1'b0;
          idx_d     = '0;
        end else begin
          state_d   = RUN;
          bit_out_d = rd_data_q;
          idx_d     = '0;
          strobe_d  = 1'b1;
          cnt_d     = pre_q;
        end
      end
      RUN: begin
        rd_addr = cur_next;
        if (stop) begin
          state_d   = IDLE;
          bit_out_d = 1'b0;
          busy_d    = 1'b0;
          idx_d     = '0;
        end else if (cnt_q == '0) begin
          if (idx_q != len_q || loop_q) begin
            bit_out_d = rd_data_q;
            idx_d     = cur_next;
            strobe_d  = 1'b1;
            cnt_d     = pre_q;
            rd_addr   = emit_next;
          end else begin
            state_d   = IDLE;
            bit_out_d = 1'b0;
            busy_d    = 1'b0;
            idx_d     = '0;
            done_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - PRESCALE_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_out_q <= 1'b0;
      strobe_q  <= 1'b0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
      pre_q     <= '0;
      loop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_out_q <= bit_out_d;
      strobe_q  <= strobe_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      pre_q     <= pre_d;
      loop_q    <= loop_d;
    end
  end

  assign bitOut    = bit_out_q;
  assign bitStrobe = strobe_q;
  assign bitIndex  = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bit_pattern_player.sv
// tb_bit_pattern_player: directed self-checking bench
// for the serial bit pattern player.
module tb_bit_pattern_player;

  localparam int AW = 14;
  localparam int PW = 15;

  logic          clk;
  logic          reset;
  logic          loadEnable;
  logic [AW-1:0] loadAddress;
  logic          loadData;
  logic [AW-1:0] length;
  logic [PW-1:0] prescale;
  logic          loop;
  logic          start;
  logic          stop;
  logic          bitOut;
  logic          bitStrobe;
  logic [AW-1:0] bitIndex;
  logic          busy;
  logic          done;

  int total;
  int bad;
  logic [3:0] pat;

  bit_pattern_player #(
    .ADDR_WIDTH(AW),
    .PRESCALE_WIDTH(PW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .loadEnable(loadEnable),
    .loadAddress(loadAddress),
    .loadData(loadData),
    .length(length),
    .prescale(prescale),
    .loop(loop),
    .start(start),
    .stop(stop),
    .bitOut(bitOut),
    .bitStrobe(bitStrobe),
    .bitIndex(bitIndex),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_bit(input logic [AW-1:0] a, input logic d);
    loadEnable  = 1'b1;
    loadAddress = a;
    loadData    = d;
    step();
    loadEnable  = 1'b0;
  endtask

  task automatic load_pat();
    for (int i = 0; i < 4; i++) load_bit(AW'(i), pat[i]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    total++;
    if (bitOut !== 1'b0) begin
      bad++; $display("FAIL reset_bitOut got=%b exp=0", bitOut);
    end
    total++;
    if (bitStrobe !== 1'b0) begin
      bad++; $display("FAIL reset_strobe got=%b exp=0", bitStrobe);
    end
    total++;
    if (bitIndex !== '0) begin
      bad++; $display("FAIL reset_index got=%0d exp=0", bitIndex);
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done);
    end
    reset = 1'b0;
    step();
  endtask

  // Plays the 4-bit pattern with period p+1; pat/length already set.
  task automatic play_once(input int p, input string tag);
    prescale = PW'(p);
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || bitOut !== 1'b0) begin
      bad++; $display("FAIL %s_prime busy=%b bit=%b exp busy=1 bit=0", tag, busy, bitOut);
    end
    for (int c = 0; c < 4 * (p + 1); c++) begin
      step();
      total++;
      if (bitOut !== pat[c / (p + 1)] ||
          bitIndex !== AW'(c / (p + 1)) ||
          bitStrobe !== (c % (p + 1) == 0) ||
          busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL %s_cyc%0d bit=%b idx=%0d stb=%b busy=%b done=%b exp bit=%b idx=%0d stb=%b busy=1 done=0",
                 tag, c, bitOut, bitIndex, bitStrobe, busy, done,
                 pat[c / (p + 1)], c / (p + 1), (c % (p + 1) == 0));
      end
    end
    step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || bitOut !== 1'b0 || bitIndex !== '0) begin
      bad++;
      $display("FAIL %s_done done=%b busy=%b bit=%b idx=%0d exp 1 0 0 0", tag, done, busy, bitOut, bitIndex);
    end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s_after done=%b busy=%b exp 0 0", tag, done, busy);
    end
  endtask

  task automatic test_once_p0();
    pat = 4'b1101;
    load_pat();
    length = AW'(3);
    loop = 1'b0;
    play_once(0, "p0");
  endtask

  task automatic test_once_p2();
    pat = 4'b1101;
    length = AW'(3);
    loop = 1'b0;
    play_once(2, "p2");
  endtask

  task automatic test_loop_stop();
    load_bit(AW'(0), 1'b1);
    load_bit(AW'(1), 1'b0);
    length = AW'(1);
    loop = 1'b1;
    prescale = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      total++;
      if (bitOut !== (c % 2 == 0) || done !== 1'b0 || bitStrobe !== 1'b1) begin
        bad++;
        $display("FAIL loop_cyc%0d bit=%b done=%b stb=%b exp bit=%b done=0 stb=1",
                 c, bitOut, done, bitStrobe, (c % 2 == 0));
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++;
    if (bitOut !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bitStrobe !== 1'b0) begin
      bad++;
      $display("FAIL loop_stop bit=%b busy=%b done=%b stb=%b exp 0000", bitOut, busy, done, bitStrobe);
    end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL loop_stop_after done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_full_wrap();
    int n;
    load_bit('1, 1'b1);
    load_bit('0, 1'b0);
    length = '1;
    loop = 1'b1;
    prescale = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (bitIndex !== '1 && n < 20000);
    total++;
    if (bitIndex !== '1 || bitOut !== 1'b1 || n !== 16384) begin
      bad++;
      $display("FAIL wrap_last idx=%0d bit=%b steps=%0d exp idx=16383 bit=1 steps=16384", bitIndex, bitOut, n);
    end
    step();
    total++;
    if (bitIndex !== '0 || bitOut !== 1'b0 || bitStrobe !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL wrap_zero idx=%0d bit=%b stb=%b busy=%b exp 0 0 1 1", bitIndex, bitOut, bitStrobe, busy);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset_mid();
    pat = 4'b1101;
    load_pat();
    length = AW'(3);
    loop = 1'b0;
    prescale = PW'(5);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    #2 reset = 1'b1;
    #1;
    total++;
    if (bitOut !== 1'b0 || busy !== 1'b0 || bitStrobe !== 1'b0 || bitIndex !== '0) begin
      bad++;
      $display("FAIL async_reset bit=%b busy=%b stb=%b idx=%0d exp all 0", bitOut, busy, bitStrobe, bitIndex);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    play_once(5, "restart");
  endtask

  task automatic test_busy_changes();
    pat = 4'b1101;
    load_pat();
    length = AW'(3);
    loop = 1'b0;
    prescale = PW'(1);
    start = 1'b1;
    step();
    length = '0;
    prescale = PW'(7);
    loop = 1'b1;
    loadEnable = 1'b1;
    loadAddress = AW'(3);
    loadData = 1'b0;
    step();
    start = 1'b0;
    loadEnable = 1'b0;
    pat = 4'b0101;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      total++;
      if (bitOut !== pat[c / 2] || bitIndex !== AW'(c / 2) ||
          bitStrobe !== (c % 2 == 0) || done !== 1'b0) begin
        bad++;
        $display("FAIL busy_cyc%0d bit=%b idx=%0d stb=%b done=%b exp bit=%b idx=%0d stb=%b done=0",
                 c, bitOut, bitIndex, bitStrobe, done, pat[c / 2], c / 2, (c % 2 == 0));
      end
    end
    step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL busy_done done=%b busy=%b exp 1 0", done, busy);
    end
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL busy_no_restart busy=%b exp 0", busy);
    end
    start = 1'b1;
    stop = 1'b1;
    step();
    step();
    total++;
    if (busy !== 1'b0 || bitStrobe !== 1'b0) begin
      bad++; $display("FAIL start_stop_idle busy=%b stb=%b exp 0 0", busy, bitStrobe);
    end
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic test_single();
    load_bit(AW'(0), 1'b1);
    length = '0;
    loop = 1'b0;
    prescale = PW'(1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    total++;
    if (bitOut !== 1'b1 || bitStrobe !== 1'b1) begin
      bad++; $display("FAIL single_b0 bit=%b stb=%b exp 1 1", bitOut, bitStrobe);
    end
    step();
    total++;
    if (bitOut !== 1'b1 || bitStrobe !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL single_b1 bit=%b stb=%b done=%b exp 1 0 0", bitOut, bitStrobe, done);
    end
    step();
    total++;
    if (done !== 1'b1 || bitOut !== 1'b0) begin
      bad++; $display("FAIL single_done done=%b bit=%b exp 1 0", done, bitOut);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    loadEnable = 1'b0;
    loadAddress = '0;
    loadData = 1'b0;
    length = '0;
    prescale = '0;
    loop = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    pat = 4'b0;
    test_reset();
    test_once_p0();
    test_once_p2();
    test_loop_stop();
    test_full_wrap();
    test_reset_mid();
    test_busy_changes();
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
